// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores to an internal RAM with wait states,
// a registered write-back bundle and branch resolution.
module mem_stage #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        zero,
    input  logic        reg_write,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_res,
    input  logic [31:0] wr_data,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_alu_res,
    output logic [31:0] out_rd_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_to_reg,
    output logic        pc_src,
    output logic        misaligned
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_next;
    logic [2:0]        cnt, cnt_next;

    logic              op_read, op_write, op_branch, op_zero, op_reg_write;
    logic [4:0]        op_rd;
    logic [31:0]       op_alu, op_wdata;

    logic              src_read, src_write, src_branch, src_zero, src_reg_write;
    logic [4:0]        src_rd;
    logic [31:0]       src_alu, src_wdata;

    logic              accept, complete, src_mis, store_en, load_ok;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       ram [DEPTH];

    assign stall  = (state == ACCESS);
    assign accept = (state == IDLE) && in_valid;

    // An op completing straight out of IDLE uses the live inputs; a waited op uses its captured copy.
    assign src_read      = (state == IDLE) ? mem_read  : op_read;
    assign src_write     = (state == IDLE) ? mem_write : op_write;
    assign src_branch    = (state == IDLE) ? branch    : op_branch;
    assign src_zero      = (state == IDLE) ? zero      : op_zero;
    assign src_reg_write = (state == IDLE) ? reg_write : op_reg_write;
    assign src_rd        = (state == IDLE) ? rd_in     : op_rd;
    assign src_alu       = (state == IDLE) ? alu_res   : op_alu;
    assign src_wdata     = (state == IDLE) ? wr_data   : op_wdata;

    assign complete = (accept && (!(mem_read || mem_write) || WAIT == 0))
                   || ((state == ACCESS) && (cnt == 3'd1));
    assign src_mis  = (src_read || src_write) && (src_alu[1:0] != 2'b00);
    assign idx      = src_alu[ADDR_W+1:2];
    assign store_en = complete && src_write && !src_mis && rst_n;
    assign load_ok  = src_read && !src_mis;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept && (mem_read || mem_write) && WAIT != 0) begin
                    state_next = ACCESS;
                    cnt_next   = WAIT_CNT;
                end
            end
            ACCESS: begin
                if (cnt == 3'd1) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_read      <= 1'b0;
            op_write     <= 1'b0;
            op_branch    <= 1'b0;
            op_zero      <= 1'b0;
            op_reg_write <= 1'b0;
            op_rd        <= 5'd0;
            op_alu       <= 32'd0;
            op_wdata     <= 32'd0;
        end else if (accept) begin
            op_read      <= mem_read;
            op_write     <= mem_write;
            op_branch    <= branch;
            op_zero      <= zero;
            op_reg_write <= reg_write;
            op_rd        <= rd_in;
            op_alu       <= alu_res;
            op_wdata     <= wr_data;
        end
    end

    // RAM is deliberately unreset; the old word is read before any store on the same edge.
    always_ff @(posedge clk) begin
        if (store_en) begin
            ram[idx] <= src_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            pc_src         <= 1'b0;
            misaligned     <= 1'b0;
            out_alu_res    <= 32'd0;
            out_rd_data    <= 32'd0;
            out_rd         <= 5'd0;
            out_reg_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
        end else begin
            out_valid  <= complete;
            pc_src     <= complete && src_branch && src_zero;
            misaligned <= complete && src_mis;
            if (complete) begin
                out_alu_res    <= src_alu;
                out_rd_data    <= load_ok ? ram[idx] : 32'd0;
                out_rd         <= src_rd;
                out_reg_write  <= src_reg_write && !src_mis;
                out_mem_to_reg <= load_ok;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes model results, monitor pops on out_valid.
module tb_mem_stage;

    localparam int WAIT   = 2;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic        clk, rst_n, in_valid, mem_read, mem_write, branch, zero, reg_write;
    logic [4:0]  rd_in;
    logic [31:0] alu_res, wr_data;
    logic        stall, out_valid, out_reg_write, out_mem_to_reg, pc_src, misaligned;
    logic [31:0] out_alu_res, out_rd_data;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        pc_src;
        logic        mis;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram_m [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    mem_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .zero(zero), .reg_write(reg_write),
        .rd_in(rd_in), .alu_res(alu_res), .wr_data(wr_data), .stall(stall),
        .out_valid(out_valid), .out_alu_res(out_alu_res), .out_rd_data(out_rd_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .pc_src(pc_src), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("latency_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                checkOutput("out_alu_res", out_alu_res, mon_e.alu);
                checkOutput("out_rd_data", out_rd_data, mon_e.rd_data);
                checkOutput("out_rd", 32'(out_rd), 32'(mon_e.rd));
                checkOutput("out_reg_write", 32'(out_reg_write), 32'(mon_e.reg_write));
                checkOutput("out_mem_to_reg", 32'(out_mem_to_reg), 32'(mon_e.mem_to_reg));
                checkOutput("pc_src", 32'(pc_src), 32'(mon_e.pc_src));
                checkOutput("misaligned", 32'(misaligned), 32'(mon_e.mis));
            end
        end
    end

    task automatic applyStimulus(input logic mr, input logic mw, input logic br, input logic z,
                                 input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] wd);
        exp_t              e;
        int                budget;
        logic              is_mem, mis;
        logic [ADDR_W-1:0] ix;
        @(negedge clk);
        mem_read = mr; mem_write = mw; branch = br; zero = z;
        reg_write = rw; rd_in = rd; alu_res = alu; wr_data = wd; in_valid = 1'b1;
        budget = 0;
        while (stall && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (stall) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=stalled required=accepted");
            in_valid = 1'b0;
            return;
        end
        is_mem = mr || mw;
        mis    = is_mem && (alu % 4 != 0);
        ix     = ADDR_W'((alu / 4) % DEPTH);
        e.alu        = alu;
        e.rd         = rd;
        e.rd_data    = (mr && !mis) ? ram_m[ix] : 32'd0;
        e.mem_to_reg = mr && !mis;
        e.reg_write  = rw && !mis;
        e.pc_src     = br && z;
        e.mis        = mis;
        e.done_cyc   = cyc + 1 + (is_mem ? WAIT : 0);
        if (mw && !mis) ram_m[ix] = wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        alu_res   = $urandom;
        wr_data   = $urandom;
        rd_in     = 5'($urandom);
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        branch    = 1'($urandom);
        zero      = 1'($urandom);
        reg_write = 1'($urandom);
        checkOutput("stall_after_accept", 32'(stall), 32'(is_mem && WAIT > 0));
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        branch = 1'b0; zero = 1'b0; reg_write = 1'b0; rd_in = 5'd0;
        alu_res = 32'd0; wr_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_alu_res", out_alu_res, 32'd0);
        checkOutput("reset_out_rd_data", out_rd_data, 32'd0);
        checkOutput("reset_out_rd", 32'(out_rd), 32'd0);
        checkOutput("reset_out_reg_write", 32'(out_reg_write), 32'd0);
        checkOutput("reset_out_mem_to_reg", 32'(out_mem_to_reg), 32'd0);
        checkOutput("reset_pc_src", 32'(pc_src), 32'd0);
        checkOutput("reset_misaligned", 32'(misaligned), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every RAM word a known value; word 3 (0x0C) holds zero.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'(i * 4), (i == 3) ? 32'd0 : $urandom);
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0010, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0008, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0008, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0100, 32'h0000_1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_0000, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0006, 32'h0000_0055);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0004, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0000_0008, 32'h0BAD_F00D);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0040, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0044, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(11 + i), 32'h100 + 32'(i), 32'd0);
        end
        drain();

        // Reset in the middle of a store: nothing must reach the RAM.
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; branch = 1'b0; zero = 1'b0; reg_write = 1'b0;
        rd_in = 5'd0; alu_res = 32'h0000_000C; wr_data = 32'hA5A5_A5A5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("midreset_stall_before", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_stall", 32'(stall), 32'd0);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_out_alu_res", out_alu_res, 32'd0);
        checkOutput("midreset_out_rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd20, 32'h0000_000C, 32'd0);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 5'($urandom), a, $urandom);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
